// File: rtl/jam_pkg.sv
// Shared types and elaboration helpers for the job-assignment search engine.
package jam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EVAL,
    STEP,
    DONE
  } state_t;

  // Ceiling log2, used to size index and sum widths
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // N! for sanity-checking the match counter width
  function automatic longint unsigned factorial(input int unsigned n);
    longint unsigned f;
    f = 64'd1;
    for (int unsigned i = 2; i <= n; i++) f = f * 64'(i);
    return f;
  endfunction

endpackage

// File: rtl/jam_perm_step.sv
// Holds the current permutation and advances it to the next one in lexicographic order.
module jam_perm_step
  import jam_pkg::*;
#(
  parameter  int unsigned N  = 8,
  localparam int unsigned IW = clog2(N)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 go,
  input  logic                 clr,
  output logic [N-1:0][IW-1:0] perm,
  output logic                 last_c,
  output logic                 done
);

  logic [N-1:0][IW-1:0] swp_c;
  logic [N-1:0][IW-1:0] nxt_c;
  logic [IW-1:0]        piv_c;
  logic [IW-1:0]        k_c;
  logic [IW-1:0]        src_c;
  logic                 found_c;

  // Next permutation: rightmost ascent pivot, swap with rightmost larger element, reverse suffix
  always_comb begin
    piv_c   = '0;
    k_c     = '0;
    src_c   = '0;
    found_c = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      if (perm[i] < perm[i+1]) begin
        piv_c   = IW'(i);
        found_c = 1'b1;
      end
    end
    for (int m = 0; m < N; m++) begin
      if (IW'(m) > piv_c && perm[m] > perm[piv_c]) k_c = IW'(m);
    end
    swp_c        = perm;
    swp_c[piv_c] = perm[k_c];
    swp_c[k_c]   = perm[piv_c];
    nxt_c        = swp_c;
    for (int m = 0; m < N; m++) begin
      if (IW'(m) > piv_c) begin
        src_c    = IW'(N - 1 - m) + piv_c + IW'(1);
        nxt_c[m] = swp_c[src_c];
      end
    end
    last_c = !found_c;
  end

  // Permutation register: identity on reset/clear, advance on go with a one-cycle done
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N; i++) perm[i] <= IW'(i);
      done <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < N; i++) perm[i] <= IW'(i);
      done <= 1'b0;
    end else if (go) begin
      perm <= nxt_c;
      done <= 1'b1;
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/jam_search.sv
// Exhaustive job-assignment search: loads an N x N cost matrix, scores every permutation,
// and reports the best cost, how many assignments reach it, and the first one found.
module jam_search
  import jam_pkg::*;
#(
  parameter  int unsigned N   = 8,
  parameter  int unsigned CW  = 7,
  parameter  int unsigned MCW = 16,
  localparam int unsigned IW  = clog2(N),
  localparam int unsigned SW  = CW + clog2(N)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            START,
  input  logic            FIND_MAX,
  output logic [IW-1:0]   W,
  output logic [IW-1:0]   J,
  input  logic [CW-1:0]   Cost,
  output logic            Busy,
  output logic            Valid,
  output logic [SW-1:0]   MinCost,
  output logic [MCW-1:0]  MatchCount,
  output logic [N*IW-1:0] BestJob
);

  state_t               state_q;
  state_t               state_d;
  logic                 go_c;
  logic                 clr_c;
  logic                 last_c;
  logic                 step_done;
  logic [N-1:0][IW-1:0] perm;
  logic [CW-1:0]        mat_q [N][N];
  logic                 find_max_q;
  logic                 first_q;
  logic [SW-1:0]        sum_c;
  logic                 better_c;
  logic                 equal_c;

  jam_perm_step #(.N(N)) u_step (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .go     (go_c),
    .clr    (clr_c),
    .perm   (perm),
    .last_c (last_c),
    .done   (step_done)
  );

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and permutation-step control
  always_comb begin
    state_d = state_q;
    go_c    = 1'b0;
    clr_c   = 1'b0;
    case (state_q)
      IDLE:    if (START) state_d = LOAD;
      LOAD:    if (W == IW'(N - 1) && J == IW'(N - 1)) state_d = EVAL;
      EVAL: begin
        if (last_c) begin
          state_d = DONE;
          clr_c   = 1'b1;
        end else begin
          state_d = STEP;
          go_c    = 1'b1;
        end
      end
      STEP:    if (step_done) state_d = EVAL;
      DONE:    if (START) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Cost of the current assignment
  always_comb begin
    sum_c = '0;
    for (int w = 0; w < N; w++) sum_c = sum_c + SW'(mat_q[w][perm[w]]);
  end

  assign better_c = first_q || (find_max_q ? (sum_c > MinCost) : (sum_c < MinCost));
  assign equal_c  = (sum_c == MinCost);

  // Matrix load, result tracking and handshake outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      W          <= '0;
      J          <= '0;
      Busy       <= 1'b0;
      Valid      <= 1'b0;
      MinCost    <= '0;
      MatchCount <= '0;
      BestJob    <= '0;
      find_max_q <= 1'b0;
      first_q    <= 1'b0;
      for (int a = 0; a < N; a++)
        for (int b = 0; b < N; b++) mat_q[a][b] <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (START) begin
            find_max_q <= FIND_MAX;
            first_q    <= 1'b1;
            Busy       <= 1'b1;
            Valid      <= 1'b0;
            W          <= '0;
            J          <= '0;
          end
        end
        LOAD: begin
          mat_q[W][J] <= Cost;
          if (J == IW'(N - 1)) begin
            J <= '0;
            W <= (W == IW'(N - 1)) ? '0 : W + IW'(1);
          end else begin
            J <= J + IW'(1);
          end
        end
        EVAL: begin
          if (better_c) begin
            MinCost    <= sum_c;
            MatchCount <= MCW'(1);
            BestJob    <= perm;
          end else if (equal_c && MatchCount != '1) begin
            MatchCount <= MatchCount + MCW'(1);
          end
          first_q <= 1'b0;
          if (last_c) begin
            Busy  <= 1'b0;
            Valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // MatchCount must be able to hold N!
  always_ff @(posedge CLK) begin
    assert (MCW >= 63 || (64'd1 << MCW) > factorial(N))
      else $error("MatchCount width too small for N!");
  end

endmodule
